// File: rtl/adc_sample_averager.sv
// ----------------------------------------------------------------------------
// adc_sample_averager
//   Issues periodic conversion requests to an upstream ADC interface,
//   accumulates 2^LOG2_AVG returned samples, and presents their truncated
//   mean on a valid/ready output.
//   Two sticky flags report a rate tick that arrived while a request was
//   still outstanding, and a result that was lost because the output was
//   stalled.
//
// Ports
//   clk_i            system clock; every flop uses its rising edge
//   rst_i            synchronous, active-high reset
//   enable_i         high = produce periodic conversion requests
//   clear_i          one-cycle pulse that clears both sticky flags
//   adc_request_o    conversion request to the ADC SPI interface
//   adc_data_i       12-bit sample, qualified by adc_data_valid_i
//   adc_data_valid_i one-cycle strobe for a completed sample
//   avg_data_o       averaged 12-bit result
//   avg_valid_o      result valid; held until it is accepted
//   avg_ready_i      downstream accepts the result when high with avg_valid_o
//   tick_miss_o      sticky: rate tick seen while a request was outstanding
//   result_drop_o    sticky: new result discarded because the output stalled
// ----------------------------------------------------------------------------
module adc_sample_averager #(
    parameter int unsigned CLK_FREQ_HZ    = 100000000,
    parameter int unsigned SAMPLE_RATE_HZ = 1000000,
    parameter int          LOG2_AVG       = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        clear_i,
    output logic        adc_request_o,
    input  logic [11:0] adc_data_i,
    input  logic        adc_data_valid_i,
    output logic [11:0] avg_data_o,
    output logic        avg_valid_o,
    input  logic        avg_ready_i,
    output logic        tick_miss_o,
    output logic        result_drop_o
);

    localparam int unsigned PERIOD = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
    localparam int RCW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int AW  = 12 + LOG2_AVG;
    localparam int CW  = (LOG2_AVG > 0) ? LOG2_AVG : 1;

    localparam logic [RCW-1:0] RATE_LAST = RCW'(PERIOD - 1);
    localparam logic [RCW-1:0] RATE_ONE  = RCW'(1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'((1 << LOG2_AVG) - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    if ((PERIOD < 2) || (LOG2_AVG < 0) || (LOG2_AVG > 8)) begin : g_bad_params
        $fatal(1, "adc_sample_averager: needs CLK_FREQ_HZ/SAMPLE_RATE_HZ >= 2 and LOG2_AVG in 0..8");
    end

    logic [RCW-1:0] rate_cnt_q, rate_cnt_d;
    logic [0:0]     state_q, state_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [11:0]    avg_data_q, avg_data_d;
    logic           avg_valid_q, avg_valid_d;
    logic           tick_miss_q, tick_miss_d;
    logic           result_drop_q, result_drop_d;

    logic           tick_s;
    logic           miss_set_s;
    logic           drop_set_s;
    logic           new_result_s;
    logic [AW-1:0]  sum_s;
    logic [11:0]    result_s;

    // Rate counter: counts enabled cycles and emits a tick on the last one of each period.
    always_comb begin
        rate_cnt_d = rate_cnt_q;
        tick_s     = 1'b0;
        if (!enable_i) begin
            rate_cnt_d = {RCW{1'b0}};
        end else if (rate_cnt_q == RATE_LAST) begin
            rate_cnt_d = {RCW{1'b0}};
            tick_s     = 1'b1;
        end else begin
            rate_cnt_d = rate_cnt_q + RATE_ONE;
        end
    end

    // Request FSM: one outstanding conversion at a time; ticks in PENDING are dropped.
    always_comb begin
        state_d    = state_q;
        miss_set_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    state_d = PENDING;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                miss_set_s = tick_s;
                if (adc_data_valid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = PENDING;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The strobe cycle masks the request so the ADC never sees a chained conversion.
    assign adc_request_o = (state_q == PENDING) && !adc_data_valid_i;

    // Accumulator: the sum of 2^LOG2_AVG 12-bit samples fits in 12+LOG2_AVG bits.
    always_comb begin
        sum_s        = acc_q + AW'(adc_data_i);
        result_s     = sum_s[AW-1:LOG2_AVG];
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        new_result_s = 1'b0;
        if (adc_data_valid_i) begin
            if (cnt_q == CNT_LAST) begin
                acc_d        = {AW{1'b0}};
                cnt_d        = {CW{1'b0}};
                new_result_s = 1'b1;
            end else begin
                acc_d = sum_s;
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Output register: a stalled result is never overwritten; a new result is dropped instead.
    always_comb begin
        avg_data_d  = avg_data_q;
        avg_valid_d = avg_valid_q;
        drop_set_s  = 1'b0;
        if (new_result_s) begin
            if (!avg_valid_q || avg_ready_i) begin
                avg_data_d  = result_s;
                avg_valid_d = 1'b1;
            end else begin
                drop_set_s = 1'b1;
            end
        end else if (avg_valid_q && avg_ready_i) begin
            avg_valid_d = 1'b0;
        end else begin
            avg_valid_d = avg_valid_q;
        end
    end

    // Sticky flags: a set condition wins over a coincident clear.
    always_comb begin
        tick_miss_d   = tick_miss_q;
        result_drop_d = result_drop_q;
        if (miss_set_s) begin
            tick_miss_d = 1'b1;
        end else if (clear_i) begin
            tick_miss_d = 1'b0;
        end else begin
            tick_miss_d = tick_miss_q;
        end
        if (drop_set_s) begin
            result_drop_d = 1'b1;
        end else if (clear_i) begin
            result_drop_d = 1'b0;
        end else begin
            result_drop_d = result_drop_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rate_cnt_q    <= {RCW{1'b0}};
            state_q       <= IDLE;
            acc_q         <= {AW{1'b0}};
            cnt_q         <= {CW{1'b0}};
            avg_data_q    <= 12'h000;
            avg_valid_q   <= 1'b0;
            tick_miss_q   <= 1'b0;
            result_drop_q <= 1'b0;
        end else begin
            rate_cnt_q    <= rate_cnt_d;
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            avg_data_q    <= avg_data_d;
            avg_valid_q   <= avg_valid_d;
            tick_miss_q   <= tick_miss_d;
            result_drop_q <= result_drop_d;
        end
    end

    assign avg_data_o    = avg_data_q;
    assign avg_valid_o   = avg_valid_q;
    assign tick_miss_o   = tick_miss_q;
    assign result_drop_o = result_drop_q;

endmodule
